gray_track_rx: RTL and testbench
================================

# gray_track_rx

Receiver side of the 3-bit Gray-code counter link: the block samples a 3-bit Gray code produced by an up/down Gray counter (G[2] = MSB), decodes it to binary and reconstructs step events, direction and an absolute position. A transition that skips codes is reported as an error. It sits between the Gray counter outputs and the downstream position and display logic.

## Interface
- POS_W, 8, width of the accumulated position counter (wraps modulo 2^POS_W)
- clk  in  1  single clock; every register updates on its rising edge
- reset  in  1  synchronous, active-high; takes effect on the rising clk edge where it is high
- en  in  1  sample strobe; G is captured only on edges with en = 1
- clr  in  1  synchronous clear of position and fault; returns the block to INIT
- G  in  3  Gray code {Y1, Y2, Y3}: G[2] = b2, G[1] = b2^b1, G[0] = b1^b0
- bin  out  3  binary value of the last accepted sample
- pos  out  POS_W  signed-wrap position accumulator (two's complement)
- step  out  1  one-cycle pulse, one valid ±1 move detected
- dir  out  1  direction of the last step: 1 = up (+1), 0 = down (−1); held between steps
- err  out  1  one-cycle pulse, illegal transition detected
- locked  out  1  high in TRACK

## Operation
- Decoding: b2 = G[2]; b1 = G[2]^G[1]; b0 = G[2]^G[1]^G[0].
- FSM states: INIT, TRACK, FAULT.
- INIT: on en, load bin with the decoded sample and go to TRACK. No step and no err are produced.
- TRACK, on en: compute delta = (new − bin) mod 8.
  - delta 0: no event.
  - delta 1: step = 1, dir = 1, pos + 1.
  - delta 7: step = 1, dir = 0, pos − 1.
  - delta 2..6: err = 1, pos unchanged, go to FAULT.
  - bin is loaded with the new value in every TRACK case, including the error case.
- FAULT: bin still follows accepted samples. No step is produced and pos is frozen. The block leaves FAULT only through clr or reset.
- clr has priority over en: pos = 0, step = 0, err = 0, state goes to INIT, and a sample on the same edge is ignored. bin is not changed.
- reset has priority over everything.
- pos wraps: from 2^(POS_W−1)−1 it goes +1 to −2^(POS_W−1), and the reverse going −1.
- bin wrap-around is legal: 7→0 is +1 and 0→7 is −1.

## Timing
- All outputs are registered. The edge that captures G with en = 1 also updates bin, pos, step, dir and err. Latency is 1 clock.
- step and err are high for exactly one cycle per event. They are 0 on every edge with en = 0.
- Back-to-back en edges can produce one step per cycle.
- Reset values: state = INIT, bin = 0, pos = 0, step = 0, dir = 0, err = 0, locked = 0.
- Reset or clr asserted in the middle of a run clears the block on that edge. The next en re-locks through INIT.

## Structure
- Package gray_track_pkg holds:
  - the state enum {INIT, TRACK, FAULT}
  - constant GRAY_W = 3
  - the DELTA_UP = 1 and DELTA_DN = 7 constants
- Sub-module gray2bin: a purely combinational 3-bit Gray-to-binary decoder. It is instantiated once on G.
- The FSM, the delta compare and the pos accumulator live in the top module.

## Test plan
- Reset, then first sample: hold reset for 2 cycles, then en with G = 3'b010 → bin = 3, step = 0, err = 0, locked = 1, pos = 0.
- Up sweep: after the lock at 0, apply G = 001, 011, 010, 110, 111, 101, 100, 000 on consecutive en cycles.
  - Required: 8 step pulses, each with dir = 1.
  - At the end: pos = 8 and bin = 0, covering the 7→0 wrap.
- Down with idle gaps:
  - Start from bin = 0 with en = 0 cycles between samples.
  - Apply G = 100 → bin = 7, dir = 0, pos = −1 (0xFF).
  - Idle en = 0 cycles produce no pulses.
- Illegal jump: in TRACK at bin = 1, sample G = 111 (bin = 5) → err pulses for one cycle, locked = 0 (FAULT), pos unchanged. Later legal moves produce no step.
- clr priority: in FAULT, assert clr and en together with any G → state = INIT, pos = 0, sample ignored. The next en re-locks with no step.
- pos wrap: with POS_W = 8, drive pos to 127, then take one up step → pos = −128 (0x80) and step = 1.

Source files
------------

// File: rtl/gray_track_pkg.sv
// Shared types and constants for the 3-bit Gray-code receiver.
package gray_track_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam int GRAY_W = 3;

   // Modulo-8 differences that count as a single legal move.
   localparam logic [GRAY_W-1:0] DELTA_UP = 3'd1;
   localparam logic [GRAY_W-1:0] DELTA_DN = 3'd7;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin
   import gray_track_pkg::*;
(
   input  logic [GRAY_W-1:0] g,
   output logic [GRAY_W-1:0] b
);

   generate
      for (genvar gi = 0; gi < GRAY_W; gi++) begin : g_bit
         assign b[gi] = ^g[GRAY_W-1:gi];
      end
   endgenerate

endmodule

// File: rtl/gray_track_rx.sv
// Gray-code link receiver: decodes samples, reports +/-1 steps, tracks position, flags skipped codes.
module gray_track_rx
   import gray_track_pkg::*;
#(
   parameter int POS_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              clr,
   input  logic [GRAY_W-1:0] G,
   output logic [GRAY_W-1:0] bin,
   output logic [POS_W-1:0]  pos,
   output logic              step,
   output logic              dir,
   output logic              err,
   output logic              locked
);

   state_t              state_reg, state_next;
   logic [GRAY_W-1:0]   bin_reg, bin_next;
   logic [POS_W-1:0]    pos_reg, pos_next;
   logic                step_reg, step_next;
   logic                dir_reg, dir_next;
   logic                err_reg, err_next;
   logic [GRAY_W-1:0]   dec;
   logic [GRAY_W-1:0]   delta;

   gray2bin u_gray2bin (
      .g (G),
      .b (dec)
   );

   // Wraps naturally, so 7->0 reads as +1 and 0->7 as -1.
   assign delta = dec - bin_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= INIT;
         bin_reg   <= '0;
         pos_reg   <= '0;
         step_reg  <= 1'b0;
         dir_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         bin_reg   <= bin_next;
         pos_reg   <= pos_next;
         step_reg  <= step_next;
         dir_reg   <= dir_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      bin_next   = bin_reg;
      pos_next   = pos_reg;
      step_next  = 1'b0;
      dir_next   = dir_reg;
      err_next   = 1'b0;
      // clr drops any sample on the same edge and leaves bin untouched.
      if (clr) begin
         state_next = INIT;
         pos_next   = '0;
      end else if (en) begin
         bin_next = dec;
         unique case (state_reg)
            INIT: state_next = TRACK;
            TRACK: begin
               if (delta == DELTA_UP) begin
                  step_next = 1'b1;
                  dir_next  = 1'b1;
                  pos_next  = pos_reg + POS_W'(1);
               end else if (delta == DELTA_DN) begin
                  step_next = 1'b1;
                  dir_next  = 1'b0;
                  pos_next  = pos_reg - POS_W'(1);
               end else if (delta != '0) begin
                  err_next   = 1'b1;
                  state_next = FAULT;
               end
            end
            FAULT: state_next = FAULT;
            default: state_next = INIT;
         endcase
      end
   end

   assign bin    = bin_reg;
   assign pos    = pos_reg;
   assign step   = step_reg;
   assign dir    = dir_reg;
   assign err    = err_reg;
   assign locked = (state_reg == TRACK);

endmodule

// File: tb/tb_gray_track_rx.sv
// Table-driven bench for gray_track_rx with a queue of expected outputs per applied sample.
module tb_gray_track_rx;

   localparam int POS_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic             clr;
   logic [2:0]       G;
   logic [2:0]       bin;
   logic [POS_W-1:0] pos;
   logic             step;
   logic             dir;
   logic             err;
   logic             locked;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic             clr;
      logic             en;
      logic [2:0]       g;
      logic [2:0]       bin;
      logic [POS_W-1:0] pos;
      logic             step;
      logic             dir;
      logic             err;
      logic             locked;
   } vec_t;

   typedef struct {
      string            name;
      logic [2:0]       bin;
      logic [POS_W-1:0] pos;
      logic             step;
      logic             dir;
      logic             err;
      logic             locked;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[$];

   gray_track_rx #(.POS_W(POS_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .clr    (clr),
      .G      (G),
      .bin    (bin),
      .pos    (pos),
      .step   (step),
      .dir    (dir),
      .err    (err),
      .locked (locked)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic c, input logic e, input logic [2:0] g,
                               input logic [2:0] b, input logic [POS_W-1:0] p,
                               input logic s, input logic d, input logic er, input logic lk);
      vec_t v;
      v.clr = c; v.en = e; v.g = g; v.bin = b; v.pos = p;
      v.step = s; v.dir = d; v.err = er; v.locked = lk;
      return v;
   endfunction

   function automatic logic [2:0] to_gray(input logic [2:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check_out(input exp_t e);
      tests_run++;
      if (bin !== e.bin || pos !== e.pos || step !== e.step || dir !== e.dir ||
          err !== e.err || locked !== e.locked) begin
         tests_failed++;
         $display("[TB] FAIL %s: got bin=%0d pos=%02h step=%b dir=%b err=%b locked=%b, need bin=%0d pos=%02h step=%b dir=%b err=%b locked=%b",
                  e.name, bin, pos, step, dir, err, locked,
                  e.bin, e.pos, e.step, e.dir, e.err, e.locked);
      end else begin
         $display("[TB] %s: bin=%0d pos=%02h step=%b dir=%b err=%b locked=%b ok",
                  e.name, bin, pos, step, dir, err, locked);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      exp_t e;
      @(negedge clk);
      clr = v.clr; en = v.en; G = v.g;
      e.name = name; e.bin = v.bin; e.pos = v.pos; e.step = v.step;
      e.dir = v.dir; e.err = v.err; e.locked = v.locked;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL %s: scoreboard empty, need 1 entry", name);
      end else begin
         check_out(sb_q.pop_front());
      end
   endtask

   task automatic do_reset(input string name);
      exp_t e;
      @(negedge clk);
      reset = 1'b1; en = 1'b0; clr = 1'b0; G = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      e.name = name; e.bin = 3'd0; e.pos = '0; e.step = 1'b0;
      e.dir = 1'b0; e.err = 1'b0; e.locked = 1'b0;
      check_out(e);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; clr = 1'b0; G = 3'b000;

      // clr en g | bin pos step dir err locked
      tbl.push_back(mk(0,1,3'b010, 3,8'h00,0,0,0,1));  // first sample locks
      tbl.push_back(mk(1,1,3'b111, 3,8'h00,0,0,0,0));  // clr wins, bin kept
      tbl.push_back(mk(0,1,3'b000, 0,8'h00,0,0,0,1));  // relock at 0
      tbl.push_back(mk(0,1,3'b001, 1,8'h01,1,1,0,1));  // up sweep
      tbl.push_back(mk(0,1,3'b011, 2,8'h02,1,1,0,1));
      tbl.push_back(mk(0,1,3'b010, 3,8'h03,1,1,0,1));
      tbl.push_back(mk(0,1,3'b110, 4,8'h04,1,1,0,1));
      tbl.push_back(mk(0,1,3'b111, 5,8'h05,1,1,0,1));
      tbl.push_back(mk(0,1,3'b101, 6,8'h06,1,1,0,1));
      tbl.push_back(mk(0,1,3'b100, 7,8'h07,1,1,0,1));
      tbl.push_back(mk(0,1,3'b000, 0,8'h08,1,1,0,1));  // 7->0 wrap
      tbl.push_back(mk(0,0,3'b000, 0,8'h08,0,1,0,1));  // idle
      tbl.push_back(mk(1,0,3'b000, 0,8'h00,0,1,0,0));  // clr without en
      tbl.push_back(mk(0,1,3'b000, 0,8'h00,0,1,0,1));  // relock at 0
      tbl.push_back(mk(0,0,3'b000, 0,8'h00,0,1,0,1));  // idle
      tbl.push_back(mk(0,1,3'b100, 7,8'hFF,1,0,0,1));  // 0->7 is -1
      tbl.push_back(mk(0,0,3'b100, 7,8'hFF,0,0,0,1));  // idle
      tbl.push_back(mk(0,0,3'b110, 7,8'hFF,0,0,0,1));  // G ignored without en
      tbl.push_back(mk(0,1,3'b101, 6,8'hFE,1,0,0,1));  // down
      tbl.push_back(mk(0,1,3'b101, 6,8'hFE,0,0,0,1));  // same code, no event
      tbl.push_back(mk(0,1,3'b100, 7,8'hFF,1,1,0,1));
      tbl.push_back(mk(0,1,3'b000, 0,8'h00,1,1,0,1));
      tbl.push_back(mk(0,1,3'b001, 1,8'h01,1,1,0,1));
      tbl.push_back(mk(0,1,3'b111, 5,8'h01,0,1,1,0));  // 1->5 illegal
      tbl.push_back(mk(0,1,3'b101, 6,8'h01,0,1,0,0));  // FAULT: bin follows, no step
      tbl.push_back(mk(0,0,3'b101, 6,8'h01,0,1,0,0));
      tbl.push_back(mk(0,1,3'b100, 7,8'h01,0,1,0,0));
      tbl.push_back(mk(0,1,3'b010, 3,8'h01,0,1,0,0));  // another jump, no new err
      tbl.push_back(mk(1,1,3'b011, 3,8'h00,0,1,0,0));  // clr+en, sample ignored
      tbl.push_back(mk(0,1,3'b000, 0,8'h00,0,1,0,1));  // relock, no step
      tbl.push_back(mk(0,1,3'b001, 1,8'h01,1,1,0,1));

      do_reset("reset");
      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("vec%0d", i));

      // Reset in the middle of a run clears everything.
      do_reset("mid_reset");

      // Position wrap: climb to 127, then one more up step lands on -128.
      apply(mk(0,1,3'b000, 0,8'h00,0,0,0,1), "wrap_lock");
      for (int k = 1; k <= 128; k++) begin
         logic [2:0] b;
         logic [7:0] p;
         b = 3'(k);
         p = 8'(k);
         apply(mk(0,1,to_gray(b), b,p,1,1,0,1), $sformatf("wrap_up%0d", k));
      end
      apply(mk(0,1,to_gray(3'd7), 3'd7,8'h7F,1,0,0,1), "wrap_down");

      if (sb_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL sb_drain: got %0d entries, need 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
